// File: rtl/tron_pkg.sv
// Shared definitions for the trail writer: palette nibbles, default screen size,
// FSM state encoding and the two-pixel word packer.
package tron_pkg;

    localparam logic [3:0] BG   = 4'h0;
    localparam logic [3:0] RED  = 4'h4;
    localparam logic [3:0] BLUE = 4'h6;
    localparam logic [3:0] WALL = 4'h8;

    localparam int H_RES_DEFAULT = 640;
    localparam int V_RES_DEFAULT = 480;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        DRAW_RED  = 2'd2,
        DRAW_BLUE = 2'd3
    } tw_state_t;

    // Both pixels of a word carry the same colour; upper nibble of each byte stays 0.
    function automatic logic [15:0] pack_word(input logic [3:0] n);
        return {4'h0, n, 4'h0, n};
    endfunction

endpackage

// File: rtl/trail_writer_tick_sync.sv
// Brings the free-running frame_clk into the Clk domain and turns each of its
// rising edges into a single-cycle tick, three Clk edges after the rise.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    // [0],[1] are the synchroniser, [2] is the history bit for edge detection.
    logic [2:0] sync_reg;
    logic       tick_reg;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync_reg <= '0;
            tick_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[1:0], frame_clk};
            tick_reg <= sync_reg[1] & ~sync_reg[2];
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/trail_writer.sv
// Frame-buffer write master: full clear with border walls on request, and a
// trail block stamp for each bike on every frame tick.
module trail_writer
    import tron_pkg::*;
#(
    parameter int TRAIL_W = 4,
    parameter int TRAIL_H = 4,
    parameter int H_RES   = H_RES_DEFAULT,
    parameter int V_RES   = V_RES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start_clear,
    input  logic [9:0]  red_x,
    input  logic [9:0]  red_y,
    input  logic [9:0]  blue_x,
    input  logic [9:0]  blue_y,
    input  logic        red_en,
    input  logic        blue_en,
    output logic [18:0] write_address,
    output logic [15:0] Data_Out,
    output logic        WE,
    output logic        busy,
    output logic        clear_done
);

    localparam int          ROW_WORDS = H_RES / 2;
    localparam logic [9:0]  LAST_COL  = 10'(ROW_WORDS - 1);
    localparam logic [9:0]  LAST_ROW  = 10'(V_RES - 1);
    localparam logic [3:0]  LAST_C    = 4'(TRAIL_W / 2 - 1);
    localparam logic [3:0]  LAST_R    = 4'(TRAIL_H - 1);
    localparam logic [10:0] H_LIM     = 11'(H_RES);
    localparam logic [10:0] V_LIM     = 11'(V_RES);

    logic tick;

    frame_tick_sync u_tick_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    tw_state_t   state_reg, state_next;
    logic [9:0]  clr_col_reg, clr_col_next;
    logic [9:0]  clr_row_reg, clr_row_next;
    logic [18:0] clr_addr_reg, clr_addr_next;
    logic [3:0]  drw_c_reg, drw_c_next;
    logic [3:0]  drw_r_reg, drw_r_next;
    logic [9:0]  lat_rx_reg, lat_rx_next, lat_ry_reg, lat_ry_next;
    logic [9:0]  lat_bx_reg, lat_bx_next, lat_by_reg, lat_by_next;
    logic        lat_ren_reg, lat_ren_next, lat_ben_reg, lat_ben_next;
    logic        pend_draw_reg, pend_draw_next;
    logic        pend_clear_reg, pend_clear_next;
    logic        done_flag_reg, done_flag_next;
    logic        we_reg, we_next;
    logic [18:0] addr_reg, addr_next;
    logic [15:0] data_reg, data_next;
    logic        clear_done_reg, clear_done_next;

    // Draw position for whichever bike is currently being stamped.
    logic [9:0]  cur_x, cur_y;
    logic        cur_en;
    logic [15:0] cur_word;
    logic [10:0] px, py;
    logic [18:0] row_base, draw_addr;
    logic        in_range;

    always_comb begin
        cur_x    = lat_rx_reg;
        cur_y    = lat_ry_reg;
        cur_en   = lat_ren_reg;
        cur_word = pack_word(RED);
        if (state_reg == DRAW_BLUE) begin
            cur_x    = lat_bx_reg;
            cur_y    = lat_by_reg;
            cur_en   = lat_ben_reg;
            cur_word = pack_word(BLUE);
        end
    end

    assign px       = {1'b0, cur_x & 10'h3FE} + {6'd0, drw_c_reg, 1'b0};
    assign py       = {1'b0, cur_y} + {7'd0, drw_r_reg};
    assign in_range = (px < H_LIM) && (py < V_LIM);

    if (H_RES == 640) begin : g_row_shift
        assign row_base = ({8'd0, py} << 8) + ({8'd0, py} << 6);
    end else begin : g_row_mult
        assign row_base = 19'({8'd0, py} * 19'(ROW_WORDS));
    end

    assign draw_addr = {9'd0, px[10:1]} + row_base;

    always_comb begin
        state_next      = state_reg;
        clr_col_next    = clr_col_reg;
        clr_row_next    = clr_row_reg;
        clr_addr_next   = clr_addr_reg;
        drw_c_next      = drw_c_reg;
        drw_r_next      = drw_r_reg;
        lat_rx_next     = lat_rx_reg;
        lat_ry_next     = lat_ry_reg;
        lat_bx_next     = lat_bx_reg;
        lat_by_next     = lat_by_reg;
        lat_ren_next    = lat_ren_reg;
        lat_ben_next    = lat_ben_reg;
        pend_draw_next  = pend_draw_reg | tick;
        pend_clear_next = pend_clear_reg | (start_clear && (state_reg != CLEAR));
        done_flag_next  = 1'b0;
        clear_done_next = done_flag_reg;
        we_next         = 1'b0;
        addr_next       = '0;
        data_next       = '0;

        case (state_reg)
            IDLE: begin
                clr_col_next  = '0;
                clr_row_next  = '0;
                clr_addr_next = '0;
                drw_c_next    = '0;
                drw_r_next    = '0;
                if (pend_clear_reg) begin
                    state_next = CLEAR;
                end else if (pend_draw_reg) begin
                    lat_rx_next    = red_x;
                    lat_ry_next    = red_y;
                    lat_bx_next    = blue_x;
                    lat_by_next    = blue_y;
                    lat_ren_next   = red_en;
                    lat_ben_next   = blue_en;
                    pend_draw_next = tick;
                    state_next     = DRAW_RED;
                end
            end

            CLEAR: begin
                we_next       = 1'b1;
                addr_next     = clr_addr_reg;
                data_next     = (clr_row_reg == '0 || clr_row_reg == LAST_ROW ||
                                 clr_col_reg == '0 || clr_col_reg == LAST_COL)
                                ? pack_word(WALL) : pack_word(BG);
                clr_addr_next = clr_addr_reg + 19'd1;
                if (clr_col_reg == LAST_COL) begin
                    clr_col_next = '0;
                    clr_row_next = clr_row_reg + 10'd1;
                    if (clr_row_reg == LAST_ROW) begin
                        // Anything queued during the sweep is stale once it finishes.
                        state_next      = IDLE;
                        pend_clear_next = 1'b0;
                        pend_draw_next  = 1'b0;
                        done_flag_next  = 1'b1;
                    end
                end else begin
                    clr_col_next = clr_col_reg + 10'd1;
                end
            end

            DRAW_RED, DRAW_BLUE: begin
                if (start_clear || pend_clear_reg) begin
                    state_next = IDLE;
                end else if (!cur_en) begin
                    state_next = (state_reg == DRAW_RED) ? DRAW_BLUE : IDLE;
                end else begin
                    we_next   = in_range;
                    addr_next = in_range ? draw_addr : '0;
                    data_next = cur_word;
                    if (drw_c_reg == LAST_C) begin
                        drw_c_next = '0;
                        if (drw_r_reg == LAST_R) begin
                            drw_r_next = '0;
                            state_next = (state_reg == DRAW_RED) ? DRAW_BLUE : IDLE;
                        end else begin
                            drw_r_next = drw_r_reg + 4'd1;
                        end
                    end else begin
                        drw_c_next = drw_c_reg + 4'd1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg      <= IDLE;
            clr_col_reg    <= '0;
            clr_row_reg    <= '0;
            clr_addr_reg   <= '0;
            drw_c_reg      <= '0;
            drw_r_reg      <= '0;
            lat_rx_reg     <= '0;
            lat_ry_reg     <= '0;
            lat_bx_reg     <= '0;
            lat_by_reg     <= '0;
            lat_ren_reg    <= 1'b0;
            lat_ben_reg    <= 1'b0;
            pend_draw_reg  <= 1'b0;
            pend_clear_reg <= 1'b0;
            done_flag_reg  <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            data_reg       <= '0;
            clear_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            clr_col_reg    <= clr_col_next;
            clr_row_reg    <= clr_row_next;
            clr_addr_reg   <= clr_addr_next;
            drw_c_reg      <= drw_c_next;
            drw_r_reg      <= drw_r_next;
            lat_rx_reg     <= lat_rx_next;
            lat_ry_reg     <= lat_ry_next;
            lat_bx_reg     <= lat_bx_next;
            lat_by_reg     <= lat_by_next;
            lat_ren_reg    <= lat_ren_next;
            lat_ben_reg    <= lat_ben_next;
            pend_draw_reg  <= pend_draw_next;
            pend_clear_reg <= pend_clear_next;
            done_flag_reg  <= done_flag_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            clear_done_reg <= clear_done_next;
        end
    end

    assign WE            = we_reg;
    assign write_address = addr_reg;
    assign Data_Out      = data_reg;
    assign clear_done    = clear_done_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_trail_writer.sv
// Bench for trail_writer on a 640x24 screen: clear sweep, clipped and overlapping
// trail stamps, tick collapsing, clear-abort of a draw and reset during a clear.
module tb_trail_writer;

    localparam int HR  = 640;
    localparam int VR  = 24;
    localparam int RW  = HR / 2;
    localparam int NW  = RW * VR;
    localparam int TW  = 4;
    localparam int TH  = 4;
    localparam int CLEAR_BUDGET = NW + 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic        start_clear = 1'b0;
    logic [9:0]  red_x = '0, red_y = '0, blue_x = '0, blue_y = '0;
    logic        red_en = 1'b0, blue_en = 1'b0;
    logic [18:0] write_address;
    logic [15:0] Data_Out;
    logic        WE, busy, clear_done;

    trail_writer #(.TRAIL_W(TW), .TRAIL_H(TH), .H_RES(HR), .V_RES(VR)) dut (
        .Clk           (clk),
        .Reset         (rst_n),
        .frame_clk     (frame_clk),
        .start_clear   (start_clear),
        .red_x         (red_x),
        .red_y         (red_y),
        .blue_x        (blue_x),
        .blue_y        (blue_y),
        .red_en        (red_en),
        .blue_en       (blue_en),
        .write_address (write_address),
        .Data_Out      (Data_Out),
        .WE            (WE),
        .busy          (busy),
        .clear_done    (clear_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Write log and shadow frame buffer, captured on the falling edge.
    int          cyc = 0;
    int          busy_cnt = 0;
    logic        prev_busy = 1'b0;
    int          wq_addr[$];
    logic [15:0] wq_data[$];
    int          wq_cyc[$];
    int          rise_q[$];
    int          done_q[$];
    logic [15:0] shadow [int];

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (WE === 1'b1) begin
                wq_addr.push_back(int'(write_address));
                wq_data.push_back(Data_Out);
                wq_cyc.push_back(cyc);
                shadow[int'(write_address)] = Data_Out;
            end
            if (busy === 1'b1) begin
                busy_cnt = busy_cnt + 1;
                if (!prev_busy) rise_q.push_back(cyc);
            end
            if (clear_done === 1'b1) done_q.push_back(cyc);
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        rise_q.delete();
        done_q.delete();
        busy_cnt = 0;
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        repeat (4) @(negedge clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clear();
        start_clear = 1'b1;
        @(negedge clk);
        start_clear = 1'b0;
    endtask

    // Reference: word i lies on row i/RW, column word i%RW; walls on the frame edge.
    function automatic logic [15:0] exp_clear_word(input int i);
        int row, col;
        row = i / RW;
        col = i % RW;
        if (row == 0 || row == VR - 1 || col == 0 || col == RW - 1) return 16'h0808;
        return 16'h0000;
    endfunction

    // Reference draw: ordered expected writes with their cycle slot within the draw.
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_slot[$];
    int          exp_busy;

    task automatic model_bike(input int x, input int y, input bit en,
                              input logic [15:0] word, inout int slot);
        int px, py;
        if (!en) begin
            slot = slot + 1;
            return;
        end
        for (int r = 0; r < TH; r++) begin
            for (int c = 0; c < TW / 2; c++) begin
                px = (x / 2) * 2 + 2 * c;
                py = y + r;
                if (px < HR && py < VR) begin
                    exp_addr.push_back(px / 2 + py * RW);
                    exp_data.push_back(word);
                    exp_slot.push_back(slot);
                end
                slot = slot + 1;
            end
        end
    endtask

    task automatic model_draw(input int rx, input int ry, input bit re,
                              input int bx, input int by, input bit be);
        int slot;
        exp_addr.delete();
        exp_data.delete();
        exp_slot.delete();
        slot = 0;
        model_bike(rx, ry, re, 16'h0404, slot);
        model_bike(bx, by, be, 16'h0606, slot);
        exp_busy = slot;
    endtask

    task automatic wait_clear_done(output bit seen);
        int n;
        n = 0;
        while (clear_done !== 1'b1 && n < CLEAR_BUDGET) begin
            @(negedge clk);
            n++;
        end
        seen = (clear_done === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%b want=0", WE); end
        vectors++; if (write_address !== 19'd0) begin miscompares++; $display("FAIL reset_addr got=%0d want=0", write_address); end
        vectors++; if (Data_Out !== 16'h0) begin miscompares++; $display("FAIL reset_data got=%h want=0000", Data_Out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++; if (clear_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", clear_done); end
        clear_log();
        repeat (100) @(negedge clk);
        vectors++; if (wq_addr.size() !== 0) begin miscompares++; $display("FAIL idle_no_write got=%0d writes want=0", wq_addr.size()); end
        $display("reset: outputs checked, %0d idle writes", wq_addr.size());
    endtask

    task automatic test_clear();
        bit seen;
        int bad, last_cyc;
        clear_log();
        pulse_clear();
        wait_clear_done(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL clear_timeout got=no clear_done want=pulse within %0d", CLEAR_BUDGET); end
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL clear_done_we got=%b want=0", WE); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_done_busy got=%b want=0", busy); end
        repeat (3) @(negedge clk);
        vectors++; if (wq_addr.size() != NW) begin miscompares++; $display("FAIL clear_count got=%0d want=%0d", wq_addr.size(), NW); end
        bad = 0;
        foreach (wq_addr[i]) if (wq_addr[i] != i || wq_data[i] !== exp_clear_word(i)) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL clear_words got=%0d bad words want=0", bad); end
        vectors++; if (shadow[0] !== 16'h0808) begin miscompares++; $display("FAIL clear_addr0 got=%h want=0808", shadow[0]); end
        vectors++; if (shadow[1000] !== 16'h0000) begin miscompares++; $display("FAIL clear_addr1000 got=%h want=0000", shadow[1000]); end
        vectors++; if (shadow[NW-1] !== 16'h0808) begin miscompares++; $display("FAIL clear_last got=%h want=0808", shadow[NW-1]); end
        vectors++; if (shadow[RW] !== 16'h0808 || shadow[2*RW-1] !== 16'h0808 || shadow[RW+1] !== 16'h0000) begin
            miscompares++; $display("FAIL clear_side_walls got=%h/%h/%h want=0808/0808/0000", shadow[RW], shadow[2*RW-1], shadow[RW+1]);
        end
        last_cyc = (wq_cyc.size() > 0) ? wq_cyc[wq_cyc.size()-1] : -1;
        vectors++; if (wq_cyc.size() == 0 || last_cyc - wq_cyc[0] != NW - 1) begin
            miscompares++; $display("FAIL clear_contiguous got=span %0d want=%0d", (wq_cyc.size() > 0) ? last_cyc - wq_cyc[0] : -1, NW - 1);
        end
        vectors++; if (done_q.size() != 1 || done_q[0] - last_cyc != 1) begin
            miscompares++; $display("FAIL clear_done_timing got=%0d pulses, delay %0d want=1 pulse, delay 1", done_q.size(), (done_q.size() > 0) ? done_q[0] - last_cyc : -1);
        end
        $display("clear: %0d writes, %0d bad words, clear_done pulses %0d", wq_addr.size(), bad, done_q.size());
    endtask

    task automatic test_draws();
        int fx_rx[4] = '{101,   0, 100, 639};
        int fx_ry[4] = '{ 10,   0,   5,  23};
        int fx_re[4] = '{  1,   0,   1,   1};
        int fx_bx[4] = '{  0, 638, 102,   0};
        int fx_by[4] = '{  0,  22,   6,   0};
        int fx_be[4] = '{  0,   1,   1,   1};
        for (int k = 0; k < 14; k++) begin
            int rx, ry, bx, by, n, off;
            bit re, be;
            if (k < 4) begin
                rx = fx_rx[k]; ry = fx_ry[k]; re = fx_re[k][0];
                bx = fx_bx[k]; by = fx_by[k]; be = fx_be[k][0];
            end else begin
                rx = int'($urandom_range(0, 660)); ry = int'($urandom_range(0, 30)); re = 1'($urandom_range(0, 1));
                bx = int'($urandom_range(0, 660)); by = int'($urandom_range(0, 30)); be = 1'($urandom_range(0, 1));
            end
            red_x = 10'(rx); red_y = 10'(ry); red_en = re;
            blue_x = 10'(bx); blue_y = 10'(by); blue_en = be;
            model_draw(rx, ry, re, bx, by, be);
            clear_log();
            frame_pulse();
            repeat (40) @(negedge clk);
            vectors++; if (wq_addr.size() != exp_addr.size()) begin
                miscompares++; $display("FAIL draw%0d_count got=%0d want=%0d", k, wq_addr.size(), exp_addr.size());
            end
            vectors++; if (busy_cnt != exp_busy) begin
                miscompares++; $display("FAIL draw%0d_busy_cycles got=%0d want=%0d", k, busy_cnt, exp_busy);
            end
            vectors++; if (rise_q.size() != 1) begin
                miscompares++; $display("FAIL draw%0d_draw_count got=%0d want=1", k, rise_q.size());
            end
            n = (wq_addr.size() < exp_addr.size()) ? wq_addr.size() : exp_addr.size();
            for (int i = 0; i < n; i++) begin
                off = (rise_q.size() > 0) ? wq_cyc[i] - rise_q[0] - 1 : -1;
                $display("draw %0d write %0d: addr=%0d data=%h slot=%0d", k, i, wq_addr[i], wq_data[i], off);
                vectors++; if (wq_addr[i] != exp_addr[i] || wq_data[i] !== exp_data[i] || off != exp_slot[i]) begin
                    miscompares++;
                    $display("FAIL draw%0d_write%0d got=addr %0d data %h slot %0d want=addr %0d data %h slot %0d",
                             k, i, wq_addr[i], wq_data[i], off, exp_addr[i], exp_data[i], exp_slot[i]);
                end
            end
            if (k == 2) begin
                vectors++; if (shadow[51 + 6*RW] !== 16'h0606) begin
                    miscompares++; $display("FAIL overlap_blue_wins got=%h want=0606", shadow[51 + 6*RW]);
                end
                vectors++; if (shadow[50 + 5*RW] !== 16'h0404) begin
                    miscompares++; $display("FAIL overlap_red_only got=%h want=0404", shadow[50 + 5*RW]);
                end
            end
        end
    endtask

    task automatic test_clear_swallows_ticks();
        bit seen;
        int late;
        red_x = 10'd10; red_y = 10'd3; red_en = 1'b1;
        blue_x = 10'd20; blue_y = 10'd8; blue_en = 1'b1;
        clear_log();
        pulse_clear();
        repeat (3) frame_pulse();
        wait_clear_done(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL swallow_timeout got=no clear_done want=pulse"); end
        repeat (40) @(negedge clk);
        late = 0;
        foreach (wq_cyc[i]) if (done_q.size() > 0 && wq_cyc[i] > done_q[0]) late++;
        vectors++; if (late != 0) begin miscompares++; $display("FAIL swallow_late_writes got=%0d want=0", late); end
        vectors++; if (wq_addr.size() != NW) begin miscompares++; $display("FAIL swallow_clear_count got=%0d want=%0d", wq_addr.size(), NW); end
        vectors++; if (rise_q.size() != 1) begin miscompares++; $display("FAIL swallow_busy_periods got=%0d want=1", rise_q.size()); end
        $display("clear with 3 ticks: %0d writes, %0d after clear_done", wq_addr.size(), late);

        model_draw(10, 3, 1'b1, 20, 8, 1'b1);
        clear_log();
        frame_pulse();
        repeat (40) @(negedge clk);
        vectors++; if (wq_addr.size() != exp_addr.size()) begin miscompares++; $display("FAIL single_draw_writes got=%0d want=%0d", wq_addr.size(), exp_addr.size()); end
        vectors++; if (busy_cnt != exp_busy) begin miscompares++; $display("FAIL single_draw_cycles got=%0d want=%0d", busy_cnt, exp_busy); end
        vectors++; if (rise_q.size() != 1) begin miscompares++; $display("FAIL single_draw_count got=%0d want=1", rise_q.size()); end
        $display("single tick: %0d writes over %0d busy cycles", wq_addr.size(), busy_cnt);
    endtask

    task automatic test_abort_draw();
        bit seen;
        int n, reds;
        red_x = 10'd200; red_y = 10'd4; red_en = 1'b1;
        blue_x = 10'd300; blue_y = 10'd4; blue_en = 1'b1;
        clear_log();
        frame_clk = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        frame_clk = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_draw_start got=busy %b want=1", busy); end
        repeat (2) @(negedge clk);
        pulse_clear();
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL abort_we got=%b want=0", WE); end
        wait_clear_done(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL abort_clear_timeout got=no clear_done want=pulse"); end
        repeat (3) @(negedge clk);
        reds = 0;
        foreach (wq_data[i]) if (wq_data[i] === 16'h0404) reds++;
        vectors++; if (reds != 2) begin miscompares++; $display("FAIL abort_red_writes got=%0d want=2", reds); end
        vectors++; if (wq_addr.size() < 3 || wq_addr[2] != 0 || wq_data[2] !== 16'h0808) begin
            miscompares++; $display("FAIL abort_clear_start got=%0d entries want=write 2 at addr 0 data 0808", wq_addr.size());
        end
        vectors++; if (wq_addr.size() != NW + 2) begin miscompares++; $display("FAIL abort_total got=%0d want=%0d", wq_addr.size(), NW + 2); end
        $display("abort: %0d red writes, %0d total writes", reds, wq_addr.size());
    endtask

    task automatic test_reset_mid_clear();
        pulse_clear();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (WE !== 1'b0 || busy !== 1'b0 || write_address !== 19'd0 || Data_Out !== 16'h0) begin
            miscompares++; $display("FAIL reset_abort_outputs got=we %b busy %b addr %0d data %h want=0 0 0 0000", WE, busy, write_address, Data_Out);
        end
        rst_n = 1'b1;
        clear_log();
        repeat (50) @(negedge clk);
        vectors++; if (wq_addr.size() != 0 || busy_cnt != 0) begin
            miscompares++; $display("FAIL reset_abort_resume got=%0d writes %0d busy want=0 0", wq_addr.size(), busy_cnt);
        end
        $display("reset during clear: %0d writes afterwards", wq_addr.size());
    endtask

    initial begin
        test_reset();
        test_clear();
        test_draws();
        test_clear_swallows_ticks();
        test_abort_draw();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
